// File: rtl/adder_seq_ctrl_pkg.sv
// Shared types and elaboration helpers for the bit-serial-by-slice adder sequencer.
package adder_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Slice index width; at least one bit so a single-slice build still has a register.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_add_slice.sv
// One SLICE-bit ripple-carry chain of full-adder cells; also exposes the carry into its top bit.
module add_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [SLICE:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co    = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle add/subtract sequencer: one SLICE-bit chunk per cycle, LSB first,
// with valid/ready handshakes on operand and result sides.
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = idx_width(NSLICE);
    localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("adder_seq_ctrl: WIDTH must be a positive multiple of SLICE");
    end

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [SLICE-1:0] slice_s;
    logic             slice_co;
    logic             slice_c_msb;
    logic [WIDTH-1:0] sum_next;

    // Operands shift right each RUN cycle, so the active slice is always the low bits.
    add_slice #(.SLICE(SLICE)) u_slice (
        .x     (op_a[SLICE-1:0]),
        .y     (op_b[SLICE-1:0]),
        .ci    (carry),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_c_msb)
    );

    // NOTE: every variable assigned in always_comb gets a full default first, so no latch is inferred.
    always_comb begin
        sum_next = sum;
        sum_next[idx*SLICE +: SLICE] = slice_s;
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        carry <= sub | cin;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[idx*SLICE +: SLICE] <= slice_s;
                    carry <= slice_co;
                    op_a  <= op_a >> SLICE;
                    op_b  <= op_b >> SLICE;
                    if (idx == LAST_IDX) begin
                        // idx parks on the last slice; only an accept or reset rewinds it.
                        cout  <= slice_co;
                        ovf   <= slice_co ^ slice_c_msb;
                        zero  <= (sum_next == '0);
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl against an arithmetic reference model.
module tb_adder_seq_ctrl;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result packed as {cout, ovf, zero, sum}.
    function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic ci, input logic s);
        logic [WIDTH-1:0] yy;
        logic [WIDTH:0]   full;
        logic             c0;
        logic             v;
        yy   = s ? ~y : y;
        c0   = s ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, c0};
        v    = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return {full[WIDTH], v, (full[WIDTH-1:0] == '0), full[WIDTH-1:0]};
    endfunction

    // One complete transaction: accept, wait for result, stall, drain.
    task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic xcin, input logic xsub, input int stall,
                          input bit poke, input string name);
        logic [WIDTH+2:0] exp;
        logic [WIDTH-1:0] exp_sum;
        int               cyc;
        exp     = model(xa, xb, xcin, xsub);
        exp_sum = exp[WIDTH-1:0];

        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_wait in_ready=%b expected=1", name, in_ready);
        end

        a = xa; b = xb; cin = xcin; sub = xsub; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);

        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s accept busy=%b in_ready=%b expected busy=1 in_ready=0", name, busy, in_ready);
        end

        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (poke) in_valid = 1'($urandom);
            step();
            cyc++;
        end
        checks++;
        if (cyc !== NSLICE) begin
            failures++;
            $display("FAIL %s latency got=%0d expected=%0d", name, cyc, NSLICE);
        end

        checks++;
        if (sum !== exp_sum) begin
            failures++;
            $display("FAIL %s sum got=%h expected=%h", name, sum, exp_sum);
        end
        checks++;
        if ({cout, ovf, zero} !== exp[WIDTH+2:WIDTH]) begin
            failures++;
            $display("FAIL %s flags got cout/ovf/zero=%b%b%b expected=%b", name, cout, ovf, zero,
                     exp[WIDTH+2:WIDTH]);
        end

        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_valid = 1'($urandom);
                a = $urandom;
                b = $urandom;
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== exp_sum
                || {cout, ovf, zero} !== exp[WIDTH+2:WIDTH]) begin
                failures++;
                $display("FAIL %s stall%0d out_valid=%b in_ready=%b sum=%h expected out_valid=1 in_ready=0 sum=%h",
                         name, i, out_valid, in_ready, sum, exp_sum);
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== exp_sum) begin
            failures++;
            $display("FAIL %s drain out_valid=%b in_ready=%b busy=%b sum=%h expected 0/1/0 sum=%h",
                     name, out_valid, in_ready, busy, sum, exp_sum);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        step();
        step();
        checks++;
        if (sum !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || {cout, ovf, zero} !== 3'b000) begin
            failures++;
            $display("FAIL reset_state sum=%h out_valid=%b busy=%b cout/ovf/zero=%b%b%b expected all 0",
                     sum, out_valid, busy, cout, ovf, zero);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b busy=%b expected 1/0", in_ready, busy);
        end
    endtask

    task automatic test_directed();
        run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, "carry_wrap_zero");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0, "signed_overflow");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0, 1'b0, "sub_borrow");
    endtask

    task automatic test_stall();
        run_op(32'h0000_000F, 32'h0000_00F0, 1'b1, 1'b0, 5, 1'b1, "stall_hold");
    endtask

    task automatic test_abort();
        bit saw_valid;
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (sum !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || {cout, ovf, zero} !== 3'b000) begin
            failures++;
            $display("FAIL abort_reset sum=%h out_valid=%b busy=%b cout/ovf/zero=%b%b%b expected all 0",
                     sum, out_valid, busy, cout, ovf, zero);
        end
        step();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid === 1'b1 || busy === 1'b1) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_result saw_activity=%b expected=0", saw_valid);
        end
        run_op(32'd3, 32'd4, 1'b0, 1'b0, 0, 1'b0, "after_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) rb = ra;
            run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1,
                   $sformatf("random%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
